seg7_display_ctrl: RTL
======================

// Module: seg7_display_ctrl
// PURPOSE
//  Parametrised multi-digit 7-segment driver; successor to the fixed 4-digit hex decoder.
//  Accepts a DATA_W-bit value via valid/ready and shows it in hex or unsigned decimal.
//  Decimal uses an iterative double-dabble converter.
//  Adds leading-zero blanking, blink and registered glitch-free segment outputs.
//  Sits between datapath result registers and board HEX pins.
// PARAMETERS
//  DATA_W      16          width of displayed value (>=4)
//  NUM_DIGITS  5           digits driven; elab-time check: >=ceil(DATA_W/4) and >=decimal digits of 2^DATA_W-1
//  ACTIVE_LOW  1           1: segment on = 0 (board polarity); 0: on = 1
//  BLINK_DIV   25_000_000  clk cycles per blink half-period (>=2)
// PORTS
//  clk        in   1              single clock, all logic on rising edge
//  rst_n      in   1              synchronous active-low reset
//  in_valid   in   1              new value offered
//  in_ready   out  1              1 when idle; transfer on in_valid&&in_ready
//  in_data    in   DATA_W         value to display, sampled at transfer
//  in_mode    in   1              0 hex, 1 unsigned decimal; sampled at transfer
//  in_blank_lz in  1              1 blank leading zeros; sampled at transfer
//  blink_en   in   1              live input; 1 gates all segments off in blink-off phase
//  busy       out  1              1 while a value is being converted/loaded
//  hex_o      out  7*NUM_DIGITS   digit i at [7i+6:7i], bit order {g,f,e,d,c,b,a}
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state IDLE, hex_o all segments off (7'h7F each if ACTIVE_LOW), blink counter/phase 0.
//  in_ready = rst_n && state==IDLE; busy = state!=IDLE.
//  FSM: IDLE -(transfer, hex)-> LOAD; IDLE -(transfer, dec)-> CONV; CONV -(DATA_W shifts done)-> LOAD; LOAD -> IDLE.
//  CONV: one double-dabble step per cycle (add 3 to each BCD digit >=5, then shift in data MSB); exactly DATA_W cycles.
//  LOAD: hex_o register written at the LOAD edge; old digits stay on hex_o until then (no partial values).
//  Latency (transfer at edge k): hex -> hex_o new after edge k+1; dec -> after edge k+DATA_W+1.
//  Back-to-back: next transfer earliest at edge k+2 (hex) / k+DATA_W+2 (dec).
//  Hex: digit i = nibble i, top nibble zero-extended; digits i>=ceil(DATA_W/4) are blank.
//  Dec: digit i = BCD digit i; digits beyond the converted BCD width are blank.
//  Glyphs 0-F as standard (A,b,C,d,E,F); blank = all segments off.
//  Leading-zero blanking: digits above the most significant nonzero digit blank; digit 0 always shown (value 0 -> "0").
//  Blink: counter counts 0..BLINK_DIV-1 and wraps, phase toggles on wrap.
//   Output mask is combinational: hex_o = all-off when blink_en && phase; stored digits are unaffected.
//  in_valid while busy: ignored (no transfer); upstream holds data.
//  Reset mid-CONV/LOAD: conversion aborted, nothing loaded, hex_o all-off.
//  Mode/blank inputs are captured at transfer; changes during CONV have no effect.
// STRUCTURE
//  seg7_pkg: state_e {IDLE,CONV,LOAD}, SEG_BLANK constant, function glyph(nibble)->7b active-high, polarity helper.
//  Sub-module seg7_decode: combinational 4b->7b glyph plus blank input and ACTIVE_LOW; instantiated NUM_DIGITS times.
//  Top: FSM, shift/BCD registers, step counter ($clog2(DATA_W+1) bits), blink counter, hex_o register.
// TESTING (DATA_W=16, NUM_DIGITS=5, ACTIVE_LOW=1, BLINK_DIV=4)
//  Reset: rst_n=0 two cycles -> hex_o=35'h7FFFFFFFF, in_ready=0 during reset, 1 after, busy=0.
//  Hex 16'hBEEF, blank_lz=0 -> after 1 cycle digits3..0 = b,E,E,F; digit4 blank; busy high exactly 1 cycle.
//  Dec 16'd65535 -> hex_o unchanged until edge k+17, then digits 6,5,5,3,5; in_ready=0 for 17 cycles.
//  Dec 16'd7, blank_lz=1 -> digits4..1 blank, digit0 = 7'b1111000; value 0 -> digit0 "0" only.
//  in_valid held high with different data during CONV -> no transfer; the second value is accepted the first cycle in_ready=1.
//  blink_en=1 -> hex_o alternates all-off/value every 4 cycles; rst_n=0 during CONV -> all-off, no load afterwards.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types, glyph table and polarity helpers for the 7-segment display controller.
// Segment vectors are {g,f,e,d,c,b,a}; glyphs are produced active-high and flipped at the edge.
package seg7_pkg;

  typedef enum logic [1:0] {StIdle, StConv, StLoad} state_e;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic [6:0] glyph(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

  function automatic logic [6:0] seg_polarity(input logic [6:0] seg, input bit active_low);
    return active_low ? ~seg : seg;
  endfunction

  function automatic int unsigned hex_digits(input int unsigned w);
    return (w + 3) / 4;
  endfunction

  // Decimal digits of 2^w-1: floor(w*log10(2)) + 1.
  function automatic int unsigned dec_digits(input int unsigned w);
    return (w * 30103) / 100000 + 1;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// One digit: 4-bit value to 7-segment glyph, with forced blank and board polarity.
module seg7_decode
  import seg7_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] nibble_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = seg_polarity(blank_i ? SEG_BLANK : glyph(nibble_i), ACTIVE_LOW);
  end

endmodule

// File: rtl/seg7_display_ctrl.sv
// Multi-digit 7-segment driver: hex or iterative double-dabble decimal, leading-zero
// blanking, blink mask, and a hex_o register that only changes on a completed load.
module seg7_display_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned NUM_DIGITS = 5,
  parameter bit          ACTIVE_LOW = 1'b1,
  parameter int unsigned BLINK_DIV  = 25_000_000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    in_mode,
  input  logic                    in_blank_lz,
  input  logic                    blink_en,
  output logic                    busy,
  output logic [7*NUM_DIGITS-1:0] hex_o
);

  localparam int unsigned HEX_DIGITS = hex_digits(DATA_W);
  localparam int unsigned DEC_DIGITS = dec_digits(DATA_W);
  localparam int unsigned BCD_W      = 4 * DEC_DIGITS;
  localparam int unsigned SW         = $clog2(DATA_W + 1);
  localparam int unsigned BW         = $clog2(BLINK_DIV);

  localparam logic [SW-1:0]           STEP_LAST = SW'(DATA_W - 1);
  localparam logic [BW-1:0]           BLINK_TOP = BW'(BLINK_DIV - 1);
  localparam logic [6:0]              SEG_OFF   = seg_polarity(SEG_BLANK, ACTIVE_LOW);
  localparam logic [7*NUM_DIGITS-1:0] ALL_OFF   = {NUM_DIGITS{SEG_OFF}};

  if (NUM_DIGITS < HEX_DIGITS || NUM_DIGITS < DEC_DIGITS) begin : g_bad_digits
    $error("NUM_DIGITS too small for DATA_W");
  end

  state_e                  state_q;
  logic [DATA_W-1:0]       shift_q;
  logic [BCD_W-1:0]        bcd_q;
  logic [BCD_W-1:0]        bcd_adj;
  logic [SW-1:0]           step_q;
  logic                    mode_q;
  logic                    blank_lz_q;
  logic [7*NUM_DIGITS-1:0] hex_q;
  logic [BW-1:0]           blink_cnt_q;
  logic                    phase_q;

  logic [4*NUM_DIGITS-1:0] data_ext;
  logic [4*NUM_DIGITS-1:0] bcd_ext;
  logic [3:0]              nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   dig_blank;
  logic [7*NUM_DIGITS-1:0] seg_vec;
  logic                    nz_above;

  assign in_ready = rst_n && (state_q == StIdle);
  assign busy     = (state_q != StIdle);
  assign hex_o    = (blink_en && phase_q) ? ALL_OFF : hex_q;

  always_comb begin
    bcd_adj = bcd_q;
    for (int d = 0; d < int'(DEC_DIGITS); d++) begin
      if (bcd_q[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
    end
  end

  // Walk from the top digit down so each digit knows whether anything above it is nonzero.
  always_comb begin
    data_ext               = '0;
    data_ext[DATA_W-1:0]   = shift_q;
    bcd_ext                = '0;
    bcd_ext[BCD_W-1:0]     = bcd_q;
    nz_above               = 1'b0;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      nib[i]       = mode_q ? bcd_ext[4*i +: 4] : data_ext[4*i +: 4];
      dig_blank[i] = (i >= int'(mode_q ? DEC_DIGITS : HEX_DIGITS)) ||
                     (blank_lz_q && !nz_above && (nib[i] == 4'd0) && (i != 0));
      nz_above     = nz_above || (nib[i] != 4'd0);
    end
  end

  for (genvar g = 0; g < int'(NUM_DIGITS); g++) begin : g_digit
    seg7_decode #(
      .ACTIVE_LOW(ACTIVE_LOW)
    ) u_decode (
      .nibble_i(nib[g]),
      .blank_i (dig_blank[g]),
      .seg_o   (seg_vec[7*g +: 7])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      shift_q     <= '0;
      bcd_q       <= '0;
      step_q      <= '0;
      mode_q      <= 1'b0;
      blank_lz_q  <= 1'b0;
      hex_q       <= ALL_OFF;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      if (blink_cnt_q == BLINK_TOP) begin
        blink_cnt_q <= '0;
        phase_q     <= ~phase_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + 1'b1;
      end

      case (state_q)
        StIdle: begin
          if (in_valid) begin
            shift_q    <= in_data;
            mode_q     <= in_mode;
            blank_lz_q <= in_blank_lz;
            bcd_q      <= '0;
            step_q     <= '0;
            state_q    <= in_mode ? StConv : StLoad;
          end
        end
        StConv: begin
          bcd_q   <= {bcd_adj[BCD_W-2:0], shift_q[DATA_W-1]};
          shift_q <= {shift_q[DATA_W-2:0], 1'b0};
          step_q  <= step_q + 1'b1;
          if (step_q == STEP_LAST) state_q <= StLoad;
        end
        StLoad: begin
          hex_q   <= seg_vec;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
